// File: rtl/nvme_cq_handler.sv
// nvme_cq_handler: CQ window AXI slave, completion stream and CQ head doorbell master.
// Define CQ_CHECK_EN to drop entries whose index or phase tag does not match the expected head/phase.
module nvme_cq_handler #(
  parameter int NS_ID_WIDTH = 4,
  parameter int NS_ADDR_WIDTH = 32,
  parameter int NS_DATA_WIDTH = 128,
  parameter int NL_ADDR_WIDTH = 32,
  parameter int NL_DATA_WIDTH = 32,
  parameter int CQ_DEPTH = 16,
  parameter logic [NS_ADDR_WIDTH-1:0] CQ_BASE = 32'h0002_0400,
  parameter logic [NL_ADDR_WIDTH-1:0] CQDB_ADDR = 32'h0000_100C
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NS_ID_WIDTH-1:0]     ns_awid,
  input  logic [NS_ADDR_WIDTH-1:0]   ns_awaddr,
  input  logic [7:0]                 ns_awlen,
  input  logic [2:0]                 ns_awsize,
  input  logic [1:0]                 ns_awburst,
  input  logic                       ns_awvalid,
  output logic                       ns_awready,
  input  logic [NS_DATA_WIDTH-1:0]   ns_wdata,
  input  logic [NS_DATA_WIDTH/8-1:0] ns_wstrb,
  input  logic                       ns_wlast,
  input  logic                       ns_wvalid,
  output logic                       ns_wready,
  output logic [NS_ID_WIDTH-1:0]     ns_bid,
  output logic [1:0]                 ns_bresp,
  output logic                       ns_bvalid,
  input  logic                       ns_bready,
  output logic                       cpl_valid,
  input  logic                       cpl_ready,
  output logic [15:0]                cpl_cid,
  output logic [14:0]                cpl_status,
  output logic [15:0]                cpl_sqhd,
  output logic [NL_ADDR_WIDTH-1:0]   nl_awaddr,
  output logic                       nl_awvalid,
  input  logic                       nl_awready,
  output logic [NL_DATA_WIDTH-1:0]   nl_wdata,
  output logic [NL_DATA_WIDTH/8-1:0] nl_wstrb,
  output logic                       nl_wvalid,
  input  logic                       nl_wready,
  input  logic [1:0]                 nl_bresp,
  input  logic                       nl_bvalid,
  output logic                       nl_bready,
  output logic                       cq_err
);
  localparam int HW = $clog2(CQ_DEPTH);
  localparam logic [NS_ADDR_WIDTH-1:0] CQ_END = CQ_BASE + NS_ADDR_WIDTH'(16 * CQ_DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {DB_IDLE, DB_REQ, DB_RESP} db_state_e;
  w_state_e ws_q, ws_d;
  db_state_e dbs_q, dbs_d;
  logic init_q, oor_q, oor_d, ph_q, ph_d, err_q, err_d, cv_q, cv_d;
  logic aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic [NS_ID_WIDTH-1:0] id_q, id_d;
  logic [HW-1:0] idx_q, idx_d, head_q, head_d, db_q, db_d;
  logic [HW:0] last_q, last_d;
  logic [15:0] cid_q, cid_d, sqhd_q, sqhd_d;
  logic [14:0] st_q, st_d;
  logic [NS_ADDR_WIDTH-1:0] off;
  logic hit;
  assign off = ns_awaddr - CQ_BASE;
`ifdef CQ_CHECK_EN
  assign hit = !oor_q && idx_q == head_q && ns_wdata[112] == ph_q;
`else
  assign hit = !oor_q;
`endif
  logic unused;
  assign unused = ^{ns_awlen, ns_awsize, ns_awburst, ns_wstrb, ns_wdata[95:80], ns_wdata[63:0], ns_wdata[112], off};
  assign ns_awready = init_q && ws_q == W_IDLE;
  assign ns_wready = ws_q == W_DATA && (!cv_q || cpl_ready);
  assign ns_bvalid = ws_q == W_RESP;
  assign ns_bid = id_q;
  assign ns_bresp = {ns_bvalid && oor_q, 1'b0};
  assign cpl_valid = cv_q;
  assign cpl_cid = cid_q;
  assign cpl_status = st_q;
  assign cpl_sqhd = sqhd_q;
  assign nl_awvalid = dbs_q == DB_REQ && aw_pend_q;
  assign nl_wvalid = dbs_q == DB_REQ && w_pend_q;
  assign nl_awaddr = dbs_q == DB_REQ ? CQDB_ADDR : '0;
  assign nl_wdata = NL_DATA_WIDTH'(db_q);
  assign nl_wstrb = dbs_q == DB_REQ ? '1 : '0;
  assign nl_bready = dbs_q == DB_RESP;
  assign cq_err = err_q;
  always_comb begin
    ws_d = ws_q;
    dbs_d = dbs_q;
    oor_d = oor_q;
    ph_d = ph_q;
    err_d = err_q;
    cv_d = cv_q && !cpl_ready;
    aw_pend_d = aw_pend_q;
    w_pend_d = w_pend_q;
    id_d = id_q;
    idx_d = idx_q;
    head_d = head_q;
    db_d = db_q;
    last_d = last_q;
    cid_d = cid_q;
    sqhd_d = sqhd_q;
    st_d = st_q;
    if (ns_awready && ns_awvalid) begin
      ws_d = W_DATA;
      id_d = ns_awid;
      idx_d = off[HW+3:4];
      oor_d = ns_awaddr < CQ_BASE || ns_awaddr >= CQ_END;
    end
    if (ns_wready && ns_wvalid) begin
      idx_d = idx_q + 1'b1;
      ws_d = ns_wlast ? W_RESP : W_DATA;
      if (hit) begin
        cv_d = 1'b1;
        cid_d = ns_wdata[111:96];
        st_d = ns_wdata[127:113];
        sqhd_d = ns_wdata[79:64];
        head_d = head_q + 1'b1;
        ph_d = &head_q ? !ph_q : ph_q;
      end else begin
        err_d = 1'b1;
      end
    end
    if (ns_bvalid && ns_bready) ws_d = W_IDLE;
    // Phase is part of the comparison so a full wrap back to the same head still rings the doorbell.
    if (dbs_q == DB_IDLE && ws_q == W_IDLE && {ph_q, head_q} != last_q) begin
      dbs_d = DB_REQ;
      aw_pend_d = 1'b1;
      w_pend_d = 1'b1;
      last_d = {ph_q, head_q};
      db_d = head_q;
    end
    if (dbs_q == DB_REQ) begin
      aw_pend_d = aw_pend_q && !nl_awready;
      w_pend_d = w_pend_q && !nl_wready;
      dbs_d = (!aw_pend_q || nl_awready) && (!w_pend_q || nl_wready) ? DB_RESP : DB_REQ;
    end
    if (dbs_q == DB_RESP && nl_bvalid) begin
      dbs_d = DB_IDLE;
      err_d = err_q || nl_bresp != 2'b00;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ws_q <= W_IDLE;
      dbs_q <= DB_IDLE;
      init_q <= 1'b0;
      oor_q <= 1'b0;
      ph_q <= 1'b1;
      err_q <= 1'b0;
      cv_q <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q <= 1'b0;
      id_q <= '0;
      idx_q <= '0;
      head_q <= '0;
      db_q <= '0;
      last_q <= {1'b1, {HW{1'b0}}};
      cid_q <= '0;
      sqhd_q <= '0;
      st_q <= '0;
    end else begin
      ws_q <= ws_d;
      dbs_q <= dbs_d;
      init_q <= 1'b1;
      oor_q <= oor_d;
      ph_q <= ph_d;
      err_q <= err_d;
      cv_q <= cv_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q <= w_pend_d;
      id_q <= id_d;
      idx_q <= idx_d;
      head_q <= head_d;
      db_q <= db_d;
      last_q <= last_d;
      cid_q <= cid_d;
      sqhd_q <= sqhd_d;
      st_q <= st_d;
    end
  end
endmodule

// File: tb/tb_nvme_cq_handler.sv
// tb_nvme_cq_handler: directed CQ writes with scoreboarded completion, B and doorbell channels.
module tb_nvme_cq_handler;
  logic clk = 1'b0, rstn = 1'b0;
  logic [3:0] ns_awid, ns_bid;
  logic [31:0] ns_awaddr, nl_awaddr, nl_wdata;
  logic [7:0] ns_awlen;
  logic [2:0] ns_awsize;
  logic [1:0] ns_awburst, ns_bresp, nl_bresp;
  logic ns_awvalid, ns_awready, ns_wlast, ns_wvalid, ns_wready, ns_bvalid, ns_bready;
  logic [127:0] ns_wdata;
  logic [15:0] ns_wstrb;
  logic cpl_valid, cpl_ready;
  logic [15:0] cpl_cid, cpl_sqhd;
  logic [14:0] cpl_status;
  logic nl_awvalid, nl_awready, nl_wvalid, nl_wready, nl_bvalid, nl_bready, cq_err;
  logic [3:0] nl_wstrb;
  logic [1:0] db_resp;

  nvme_cq_handler dut (
    .clk(clk), .rstn(rstn),
    .ns_awid(ns_awid), .ns_awaddr(ns_awaddr), .ns_awlen(ns_awlen), .ns_awsize(ns_awsize),
    .ns_awburst(ns_awburst), .ns_awvalid(ns_awvalid), .ns_awready(ns_awready),
    .ns_wdata(ns_wdata), .ns_wstrb(ns_wstrb), .ns_wlast(ns_wlast), .ns_wvalid(ns_wvalid),
    .ns_wready(ns_wready), .ns_bid(ns_bid), .ns_bresp(ns_bresp), .ns_bvalid(ns_bvalid),
    .ns_bready(ns_bready), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_cid(cpl_cid),
    .cpl_status(cpl_status), .cpl_sqhd(cpl_sqhd), .nl_awaddr(nl_awaddr), .nl_awvalid(nl_awvalid),
    .nl_awready(nl_awready), .nl_wdata(nl_wdata), .nl_wstrb(nl_wstrb), .nl_wvalid(nl_wvalid),
    .nl_wready(nl_wready), .nl_bresp(nl_bresp), .nl_bvalid(nl_bvalid), .nl_bready(nl_bready),
    .cq_err(cq_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] cid; logic [14:0] st; logic [15:0] sqhd;} cpl_t;
  cpl_t cq[$];
  logic [5:0] bq[$];
  logic [31:0] dq[$];
  int n_chk = 0, n_fail = 0;
  int head_m;
  logic ph_m, err_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired, got timeout expected handshake", nm);
  endtask

  // completion monitor
  initial forever begin
    @(negedge clk);
    if (rstn && cpl_valid && cpl_ready) begin
      if (cq.size() == 0) chk("cpl_unexpected", {cpl_cid, cpl_status, cpl_sqhd}, 64'h0 - 1);
      else chk("cpl", {cpl_cid, cpl_status, cpl_sqhd}, cq.pop_front());
    end
  end

  // write response monitor
  initial forever begin
    @(negedge clk);
    if (rstn && ns_bvalid && ns_bready) begin
      if (bq.size() == 0) chk("b_unexpected", {ns_bid, ns_bresp}, 64'h0 - 1);
      else chk("b_id_resp", {ns_bid, ns_bresp}, bq.pop_front());
    end
  end

  // doorbell AXI-Lite slave and checker
  initial begin
    logic got_a, got_w;
    logic [31:0] a, d;
    logic [3:0] s;
    nl_bvalid = 1'b0;
    nl_bresp = 2'b00;
    forever begin
      got_a = 1'b0;
      got_w = 1'b0;
      while (!(got_a && got_w)) begin
        @(negedge clk);
        if (rstn && nl_awvalid && nl_awready && !got_a) begin got_a = 1'b1; a = nl_awaddr; end
        if (rstn && nl_wvalid && nl_wready && !got_w) begin got_w = 1'b1; d = nl_wdata; s = nl_wstrb; end
      end
      chk("db_addr", a, 32'h100C);
      chk("db_strb", s, 4'hF);
      if (dq.size() == 0) chk("db_unexpected", d, 64'h0 - 1);
      else chk("db_data", d, dq.pop_front());
      @(posedge clk);
      #1 nl_bvalid = 1'b1;
      nl_bresp = db_resp;
      do @(negedge clk); while (!nl_bready);
      @(posedge clk);
      #1 nl_bvalid = 1'b0;
      nl_bresp = 2'b00;
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    ns_awvalid = 1'b0; ns_wvalid = 1'b0; ns_wlast = 1'b0;
    ns_awid = '0; ns_awaddr = '0; ns_awlen = '0; ns_awsize = 3'd4; ns_awburst = 2'b01;
    ns_wdata = '0; ns_wstrb = '1; ns_bready = 1'b1;
    cpl_ready = 1'b1; nl_awready = 1'b1; nl_wready = 1'b1; db_resp = 2'b00;
    cq.delete(); bq.delete(); dq.delete();
    head_m = 0; ph_m = 1'b1; err_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {ns_awready, ns_wready, ns_bvalid, cpl_valid, nl_awvalid, nl_wvalid, nl_bready, cq_err}, 0);
    chk("rst_data", {cpl_cid, cpl_status, cpl_sqhd, ns_bresp}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("awready_after_rst", ns_awready, 1);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input int n,
                             input logic [15:0] cid0, input logic ph, input logic [14:0] st0);
    logic [31:0] off;
    logic in_range, acc;
    int idx, t;
    cpl_t e;
    off = addr - 32'h20400;
    in_range = addr >= 32'h20400 && addr < 32'h20500;
    idx = int'(off[7:4]);
    bq.push_back({id, in_range ? 2'b00 : 2'b10});
    @(posedge clk);
    #1 ns_awid = id; ns_awaddr = addr; ns_awlen = 8'(n - 1); ns_awvalid = 1'b1;
    for (t = 0; t < 50; t++) begin @(negedge clk); if (ns_awready) break; end
    if (t == 50) timeout("aw_accept");
    @(posedge clk);
    #1 ns_awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.cid = cid0 + 16'(i);
      e.st = st0 + 15'(i);
      e.sqhd = 16'h0100 + 16'(i);
      ns_wdata = '0;
      ns_wdata[79:64] = e.sqhd;
      ns_wdata[111:96] = e.cid;
      ns_wdata[112] = ph;
      ns_wdata[127:113] = e.st;
      ns_wlast = i == n - 1;
      ns_wvalid = 1'b1;
      for (t = 0; t < 100; t++) begin @(negedge clk); if (ns_wready) break; end
      if (t == 100) timeout("w_accept");
`ifdef CQ_CHECK_EN
      acc = in_range && idx == head_m && ph == ph_m;
`else
      acc = in_range;
`endif
      if (acc) begin
        cq.push_back(e);
        head_m = (head_m + 1) % 16;
        if (head_m == 0) ph_m = !ph_m;
      end else err_m = 1'b1;
      idx = (idx + 1) % 16;
      @(posedge clk);
      #1;
    end
    ns_wvalid = 1'b0;
    ns_wlast = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cq.size() == 0 && bq.size() == 0 && dq.size() == 0 && ns_awready && !cpl_valid &&
          !nl_awvalid && !nl_wvalid && !nl_bready && !nl_bvalid) break;
    end
    if (t == 300) timeout(nm);
    repeat (8) @(negedge clk);
    chk({nm, "_cq_err"}, cq_err, err_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    write_burst(32'h20400, 4'h3, 1, 16'd5, 1'b1, 15'd0);
    dq.push_back(1);
    drain("single");
    chk("single_err_clear", cq_err, 0);

    do_reset();
    write_burst(32'h20400, 4'h7, 16, 16'h40, 1'b1, 15'h10);
    dq.push_back(0);
    drain("burst16");
    write_burst(32'h20400, 4'h1, 1, 16'h77, 1'b0, 15'h3);
    dq.push_back(1);
    drain("after_wrap");

    do_reset();
    write_burst(32'h20430, 4'h2, 1, 16'd9, 1'b1, 15'd5);
`ifdef CQ_CHECK_EN
    chk("idx_mismatch_no_cpl", cq.size(), 0);
`else
    dq.push_back(1);
`endif
    drain("idx_mismatch");

    do_reset();
    cpl_ready = 1'b0;
    fork
      write_burst(32'h20400, 4'h4, 4, 16'h100, 1'b1, 15'h20);
      begin
        repeat (10) @(negedge clk);
        chk("stall_wready", ns_wready, 0);
        chk("stall_cpl_hold", cpl_valid, 1);
        @(posedge clk);
        #1 cpl_ready = 1'b1;
      end
    join
    dq.push_back(4);
    drain("stall");

    do_reset();
    write_burst(32'h30000, 4'h9, 1, 16'd1, 1'b1, 15'd0);
    drain("out_of_range");
    chk("oor_err", cq_err, 1);
    write_burst(32'h20400, 4'hA, 1, 16'h55, 1'b1, 15'd0);
    dq.push_back(1);
    drain("oor_head_kept");

    do_reset();
    nl_awready = 1'b0;
    write_burst(32'h20400, 4'h5, 1, 16'h30, 1'b1, 15'd0);
    dq.push_back(1);
    repeat (5) @(negedge clk);
    chk("db_stuck_awvalid", nl_awvalid, 1);
    write_burst(32'h20410, 4'h6, 2, 16'h31, 1'b1, 15'd0);
    dq.push_back(3);
    @(posedge clk);
    #1 nl_awready = 1'b1;
    drain("coalesce");

    do_reset();
    db_resp = 2'b10;
    write_burst(32'h20400, 4'hB, 1, 16'h66, 1'b1, 15'd0);
    dq.push_back(1);
    err_m = 1'b1;
    drain("db_slverr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
